// File: rtl/ram_sp_ctrl.sv
// Valid/ready request front-end for one single-port byte-enable RAM, with a
// 2-entry in-order response buffer that absorbs the RAM read latency.
module ram_sp_ctrl #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 256,
   parameter int OUT_REG = 1,
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int BW     = WIDTH / 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_wr_i,
   input  logic [BW-1:0]    req_byte_en_i,
   input  logic [AW-1:0]    req_addr_i,
   input  logic [WIDTH-1:0] req_data_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] rsp_data_o,
   output logic             rsp_err_o,
   output logic             ram_wr_en_o,
   output logic [BW-1:0]    ram_wr_byte_en_o,
   output logic [AW-1:0]    ram_rw_addr_o,
   output logic [WIDTH-1:0] ram_rw_data_o,
   output logic             ram_rd_en_o,
   input  logic [WIDTH-1:0] ram_rd_data_i
);

   localparam int          AW1     = AW + 1;
   localparam logic [AW:0] DEPTH_L = AW1'(DEPTH);
   localparam bit          REG_RD  = (OUT_REG != 0);

   logic [1:0]       cnt_q;
   logic             pend_q;
   logic             err_q;
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [WIDTH-1:0] buf_data_q [2];
   logic [1:0]       buf_err_q;

   logic             oor;
   logic             accept;
   logic             rd_acc;
   logic             pop;
   logic             push;
   logic             push_err;
   logic [WIDTH-1:0] push_data;
   logic [1:0]       occ;

   // Stage 0: request acceptance and RAM drive
   // Ready looks only at registered occupancy so it never depends on rsp_ready_i.
   assign occ         = cnt_q + {1'b0, pend_q};
   assign req_ready_o = rst_n_i & (occ < 2'd2);
   assign oor         = ({1'b0, req_addr_i} >= DEPTH_L);
   assign accept      = req_valid_i & req_ready_o;
   assign rd_acc      = accept & ~req_wr_i;

   assign ram_wr_en_o      = accept & req_wr_i & ~oor;
   assign ram_rd_en_o      = rd_acc & ~oor;
   assign ram_wr_byte_en_o = req_byte_en_i;
   assign ram_rw_addr_o    = req_addr_i;
   assign ram_rw_data_o    = req_data_i;

   // Stage 1: read data returns from the RAM (same cycle when unregistered)
   always_comb begin
      push      = 1'b0;
      push_err  = 1'b0;
      push_data = '0;
      if (REG_RD) begin
         push     = pend_q;
         push_err = err_q;
      end else begin
         push     = rd_acc;
         push_err = oor;
      end
      if (!push_err) push_data = ram_rd_data_i;
   end

   assign pop = rsp_valid_o & rsp_ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q    <= 2'd0;
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         pend_q <= REG_RD & rd_acc;
         if (rd_acc) err_q <= oor;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         if (push && !pop)      cnt_q <= cnt_q + 2'd1;
         else if (pop && !push) cnt_q <= cnt_q - 2'd1;
      end
   end

   // Stage 2: response buffer storage and head output
   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_data_q[wr_ptr_q] <= push_data;
         buf_err_q[wr_ptr_q]  <= push_err;
      end
   end

   assign rsp_valid_o = (cnt_q != 2'd0);
   assign rsp_data_o  = buf_data_q[rd_ptr_q];
   assign rsp_err_o   = rsp_valid_o & buf_err_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_n_i) assert (occ <= 2'd2);
   end

endmodule
